// File: rtl/bcd_timer_counter.sv
// N-digit BCD up/down timer with countdown mode, saturating/wrapping add and expiry flag.
// Define BCD_TIMER_EDGE_DETECT_EN to treat add/sub/start as raw button levels (rising-edge events).
module bcd_timer_counter #(
    parameter int DIGITS = 2,
    parameter int STEP   = 2,
    parameter int WRAP   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  add,
    input  logic                  sub,
    input  logic                  start,
    input  logic                  tick,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   value,
    output logic                  running,
    output logic                  expired,
    output logic                  ovf,
    output logic                  unf,
    output logic                  reset_out
);
    localparam int W = 4 * DIGITS;
    localparam logic [3:0] STEP_BCD = 4'(STEP);
    localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;

    state_t         state_reg, state_next;
    logic [W-1:0]   value_reg, value_next;
    logic           running_reg, running_next;
    logic           expired_reg, expired_next;
    logic           ovf_reg, ovf_next;
    logic           unf_reg, unf_next;
    logic           reset_out_reg, reset_out_next;

    logic add_ev, sub_ev, start_ev;

`ifdef BCD_TIMER_EDGE_DETECT_EN
    logic add_prev_reg, sub_prev_reg, start_prev_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            add_prev_reg   <= 1'b0;
            sub_prev_reg   <= 1'b0;
            start_prev_reg <= 1'b0;
        end else begin
            add_prev_reg   <= add;
            sub_prev_reg   <= sub;
            start_prev_reg <= start;
        end
    end

    assign add_ev   = add & ~add_prev_reg;
    assign sub_ev   = sub & ~sub_prev_reg;
    assign start_ev = start & ~start_prev_reg;
`else
    assign add_ev   = add;
    assign sub_ev   = sub;
    assign start_ev = start;
`endif

    // The decrementer is shared between sub (STEP) and countdown tick (1).
    logic [3:0]     dec_amount;
    logic [DIGITS:0] add_carry;
    logic [DIGITS:0] sub_borrow;
    logic [W-1:0]   add_sum;
    logic [W-1:0]   sub_diff;

    assign dec_amount    = sub_ev ? STEP_BCD : 4'd1;
    assign add_carry[0]  = 1'b0;
    assign sub_borrow[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] add_op;
            logic [3:0] sub_op;
            logic [4:0] add_raw;
            logic [4:0] sub_raw;

            assign add_op  = (gi == 0) ? STEP_BCD : 4'd0;
            assign sub_op  = (gi == 0) ? dec_amount : 4'd0;
            assign add_raw = {1'b0, value_reg[4*gi +: 4]} + {1'b0, add_op}
                           + {4'd0, add_carry[gi]};
            assign sub_raw = {1'b0, value_reg[4*gi +: 4]} - {1'b0, sub_op}
                           - {4'd0, sub_borrow[gi]};

            assign add_carry[gi+1]    = (add_raw > 5'd9);
            assign add_sum[4*gi +: 4] = add_carry[gi+1] ? 4'(add_raw - 5'd10) : add_raw[3:0];
            // A negative 5-bit difference has bit 4 set; its low nibble plus ten is the digit.
            assign sub_borrow[gi+1]    = sub_raw[4];
            assign sub_diff[4*gi +: 4] = sub_raw[4] ? (sub_raw[3:0] + 4'd10) : sub_raw[3:0];
        end
    endgenerate

    logic value_zero, value_one, add_zero, sub_zero;
    assign value_zero = (value_reg == '0);
    assign value_one  = (value_reg == W'(1));
    assign add_zero   = (add_sum == '0);
    assign sub_zero   = (sub_diff == '0);

    always_comb begin
        state_next     = state_reg;
        value_next     = value_reg;
        ovf_next       = 1'b0;
        unf_next       = 1'b0;
        reset_out_next = 1'b0;

        if (state_reg == EXPIRED) begin
            if (clear) begin
                state_next     = IDLE;
                value_next     = '0;
                reset_out_next = 1'b1;
            end
        end else if (clear) begin
            state_next     = IDLE;
            value_next     = '0;
            reset_out_next = 1'b1;
        end else if (start_ev) begin
            if (state_reg == IDLE && !value_zero) begin
                state_next = RUN;
            end
        end else if (add_ev && !sub_ev) begin
            ovf_next = add_carry[DIGITS];
            if (add_carry[DIGITS] && WRAP == 0) begin
                value_next = ALL_NINES;
            end else begin
                value_next     = add_sum;
                reset_out_next = add_carry[DIGITS];
            end
            // Only a wrap can land exactly on zero; a running timer then has nothing left.
            if (state_reg == RUN && WRAP != 0 && add_zero) begin
                state_next = EXPIRED;
            end
        end else if (sub_ev && !add_ev) begin
            unf_next   = sub_borrow[DIGITS];
            value_next = sub_borrow[DIGITS] ? '0 : sub_diff;
            if (state_reg == RUN && (sub_borrow[DIGITS] || sub_zero)) begin
                state_next = EXPIRED;
            end
        end else if (!add_ev && !sub_ev && tick && state_reg == RUN) begin
            value_next = sub_diff;
            if (value_one) begin
                state_next = EXPIRED;
            end
        end

        running_next = (state_next == RUN);
        expired_next = (state_next == EXPIRED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            value_reg     <= '0;
            running_reg   <= 1'b0;
            expired_reg   <= 1'b0;
            ovf_reg       <= 1'b0;
            unf_reg       <= 1'b0;
            reset_out_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            value_reg     <= value_next;
            running_reg   <= running_next;
            expired_reg   <= expired_next;
            ovf_reg       <= ovf_next;
            unf_reg       <= unf_next;
            reset_out_reg <= reset_out_next;
        end
    end

    assign value     = value_reg;
    assign running   = running_reg;
    assign expired   = expired_reg;
    assign ovf       = ovf_reg;
    assign unf       = unf_reg;
    assign reset_out = reset_out_reg;

endmodule

// File: tb/tb_bcd_timer_counter.sv
// Scoreboard bench: saturating and wrapping timers driven in parallel against a decimal-integer model.
module tb_bcd_timer_counter;
    localparam int DIGITS = 2;
    localparam int STEP   = 2;
    localparam int W      = 4 * DIGITS;
    localparam int MAXV   = 99;

    logic clk = 1'b0;
    logic reset = 1'b0, add = 1'b0, sub = 1'b0, start = 1'b0, tick = 1'b0, clear = 1'b0;

    logic [W-1:0] value0, value1;
    logic running0, expired0, ovf0, unf0, reset_out0;
    logic running1, expired1, ovf1, unf1, reset_out1;

    always #5 clk = ~clk;

    bcd_timer_counter #(.DIGITS(DIGITS), .STEP(STEP), .WRAP(0)) u_sat (
        .clk(clk), .reset(reset), .add(add), .sub(sub), .start(start), .tick(tick),
        .clear(clear), .value(value0), .running(running0), .expired(expired0),
        .ovf(ovf0), .unf(unf0), .reset_out(reset_out0)
    );

    bcd_timer_counter #(.DIGITS(DIGITS), .STEP(STEP), .WRAP(1)) u_wrap (
        .clk(clk), .reset(reset), .add(add), .sub(sub), .start(start), .tick(tick),
        .clear(clear), .value(value1), .running(running1), .expired(expired1),
        .ovf(ovf1), .unf(unf1), .reset_out(reset_out1)
    );

    // st: 0 idle, 1 running, 2 expired
    typedef struct {
        int val;
        int st;
        bit pa, ps, pg;
        bit ovf, unf, ro;
    } model_t;

    typedef struct {
        logic [W+4:0] e0;
        logic [W+4:0] e1;
    } exp_t;

    model_t m0, m1;
    exp_t   exp_q[$];
    int     total = 0;
    int     bad = 0;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int d;
        r = '0;
        d = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(d % 10);
            d = d / 10;
        end
        return r;
    endfunction

    function automatic logic [W+4:0] pack(input model_t m);
        return {to_bcd(m.val), m.st == 1, m.st == 2, m.ovf, m.unf, m.ro};
    endfunction

    function automatic model_t model_step(input model_t m, input bit r, input bit a_in,
                                          input bit s_in, input bit g_in, input bit t,
                                          input bit c, input bit wrap);
        model_t n;
        bit a, s, g;
        int res;
        n = m;
        n.ovf = 0; n.unf = 0; n.ro = 0;
        if (r) begin
            n.val = 0; n.st = 0; n.pa = 0; n.ps = 0; n.pg = 0;
            return n;
        end
`ifdef BCD_TIMER_EDGE_DETECT_EN
        a = a_in && !m.pa; s = s_in && !m.ps; g = g_in && !m.pg;
`else
        a = a_in; s = s_in; g = g_in;
`endif
        n.pa = a_in; n.ps = s_in; n.pg = g_in;
        if (m.st == 2) begin
            if (c) begin n.val = 0; n.st = 0; n.ro = 1; end
        end else if (c) begin
            n.val = 0; n.st = 0; n.ro = 1;
        end else if (g) begin
            if (m.st == 0 && m.val != 0) n.st = 1;
        end else if (a && !s) begin
            res = m.val + STEP;
            if (res > MAXV) begin
                n.ovf = 1;
                if (wrap) begin n.val = res - (MAXV + 1); n.ro = 1; end
                else n.val = MAXV;
            end else n.val = res;
            if (m.st == 1 && n.val == 0) n.st = 2;
        end else if (s && !a) begin
            res = m.val - STEP;
            if (res < 0) begin n.val = 0; n.unf = 1; end
            else n.val = res;
            if (m.st == 1 && n.val == 0) n.st = 2;
        end else if (!a && !s && t && m.st == 1) begin
            n.val = m.val - 1;
            if (n.val == 0) n.st = 2;
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, req);
        end
    endtask

    task automatic drive(input bit r, input bit a, input bit s, input bit g,
                         input bit t, input bit c);
        exp_t e;
        @(negedge clk);
        reset = r; add = a; sub = s; start = g; tick = t; clear = c;
        m0 = model_step(m0, r, a, s, g, t, c, 1'b0);
        m1 = model_step(m1, r, a, s, g, t, c, 1'b1);
        e.e0 = pack(m0);
        e.e1 = pack(m1);
        exp_q.push_back(e);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every edge the DUTs present a new registered state, compare it with the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if ({value0, running0, expired0, ovf0, unf0, reset_out0} !== e.e0) begin
                bad++;
                $display("FAIL sat_sb: got=%h want=%h", {value0, running0, expired0, ovf0, unf0, reset_out0}, e.e0);
            end
            total++;
            if ({value1, running1, expired1, ovf1, unf1, reset_out1} !== e.e1) begin
                bad++;
                $display("FAIL wrap_sb: got=%h want=%h", {value1, running1, expired1, ovf1, unf1, reset_out1}, e.e1);
            end
        end
    end

    initial begin
        m0 = '{default: 0};
        m1 = '{default: 0};
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        idle();
        chk("reset_val", 32'(value0), 32'h0);
        chk("reset_flags", {27'd0, running0, expired0, ovf0, unf0, reset_out0}, 32'h0);

        // 1: five adds
        repeat (5) drive(0, 1, 0, 0, 0, 0);
        idle();
        chk("s1_val", 32'(value0), 32'h10);
        chk("s1_ovf", 32'(ovf0), 32'h0);

        // 2: 0x98 + 2, saturate vs wrap
        repeat (44) drive(0, 1, 0, 0, 0, 0);
        idle();
        chk("s2_pre", 32'(value0), 32'h98);
        drive(0, 1, 0, 0, 0, 0);
        idle();
        chk("s2_sat_val", 32'(value0), 32'h99);
        chk("s2_sat_ovf", 32'(ovf0), 32'h1);
        chk("s2_wrap_val", 32'(value1), 32'h00);
        chk("s2_wrap_flags", {30'd0, ovf1, reset_out1}, 32'h3);
        idle();
        chk("s2_ovf_pulse", 32'(ovf0), 32'h0);

        // 3: sub to underflow, simultaneous add/sub
        repeat (48) drive(0, 0, 1, 0, 0, 0);
        idle();
        chk("s3_pre", 32'(value0), 32'h03);
        drive(0, 0, 1, 0, 0, 0);
        idle();
        chk("s3_sub1", 32'(value0), 32'h01);
        drive(0, 0, 1, 0, 0, 0);
        idle();
        chk("s3_sub2", {24'(value0), 7'd0, unf0}, {24'h0, 8'h01});
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0);
        idle();
        chk("s3_addsub", {24'(value0), 5'd0, ovf0, unf0, reset_out0}, {24'h02, 8'h00});

        // 4: countdown to expiry
        drive(0, 0, 0, 0, 0, 1);
        repeat (50) drive(0, 1, 0, 0, 0, 0);
        repeat (48) drive(0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        idle();
        chk("s4_run", {24'(value0), 7'd0, running0}, {24'h03, 8'h01});
        drive(0, 0, 0, 0, 1, 0); idle();
        chk("s4_t1", 32'(value0), 32'h02);
        drive(0, 0, 0, 0, 1, 0); idle();
        chk("s4_t2", 32'(value0), 32'h01);
        drive(0, 0, 0, 0, 1, 0); idle();
        chk("s4_t3", {24'(value0), 6'd0, running0, expired0}, {24'h00, 8'h01});
        drive(0, 1, 0, 0, 0, 0); idle();
        chk("s4_add_ign", {24'(value0), 7'd0, expired0}, {24'h00, 8'h01});
        drive(0, 0, 0, 0, 0, 1); idle();
        chk("s4_clear", {24'(value0), 6'd0, expired0, reset_out0}, {24'h00, 8'h01});
        idle();
        chk("s4_ro_pulse", 32'(reset_out0), 32'h0);

        // 5: add beats tick in RUN, reset mid-run
        repeat (10) drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        drive(0, 1, 0, 0, 1, 0);
        idle();
        chk("s5_addtick", {24'(value0), 7'd0, running0}, {24'h22, 8'h01});
        drive(1, 0, 0, 0, 0, 0);
        idle();
        chk("s5_reset", {24'(value0), 3'd0, running0, expired0, ovf0, unf0, reset_out0}, 32'h0);

        // 6: add held for four cycles
        repeat (4) drive(0, 1, 0, 0, 0, 0);
        idle();
`ifdef BCD_TIMER_EDGE_DETECT_EN
        chk("s6_held", 32'(value0), 32'h02);
`else
        chk("s6_held", 32'(value0), 32'h08);
`endif

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0);
        end
        idle();
        @(posedge clk);
        #2;
        chk("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
